// File: rtl/sprite_loader.sv
// sprite_loader
// Loads one IMG_WIDTH x IMG_HEIGHT image from a packed byte stream into
// a 4096x12 sprite RAM. Every three bytes carry two RGB 4:4:4 pixels:
//   byte0 = P0[11:4], byte1 = {P0[3:0], P1[11:8]}, byte2 = P1[7:0].
// Pixels are written in row-major order to waddr = {row[5:0], col[5:0]}.
//
// Ports
//   pclk       rising-edge clock
//   rst        synchronous active-low reset
//   start      one-cycle request to load an image (ignored while busy)
//   abort      cancels a load in progress (wins over start in IDLE)
//   din        packed pixel byte
//   din_valid  din holds a byte
//   din_ready  a byte is accepted when din_valid && din_ready
//   we         RAM write strobe (registered, one cycle per pixel)
//   waddr      RAM address {row, col}; holds its value between writes
//   wdata      RAM pixel data; holds its value between writes
//   busy       load in progress (through the DONE cycle)
//   done       one-cycle pulse together with the final pixel write
module sprite_loader #(
  parameter int IMG_WIDTH  = 48,
  parameter int IMG_HEIGHT = 64
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        we,
  output logic [11:0] waddr,
  output logic [11:0] wdata,
  output logic        busy,
  output logic        done
);

  if (IMG_WIDTH < 1 || IMG_WIDTH > 64) begin : g_bad_width
    $error("sprite_loader: IMG_WIDTH must be in 1..64");
  end
  if (IMG_HEIGHT < 1 || IMG_HEIGHT > 64) begin : g_bad_height
    $error("sprite_loader: IMG_HEIGHT must be in 1..64");
  end
  if (((IMG_WIDTH * IMG_HEIGHT) % 2) != 0) begin : g_bad_area
    $error("sprite_loader: IMG_WIDTH*IMG_HEIGHT must be even");
  end

  localparam logic [5:0] COL_LAST = 6'(IMG_WIDTH - 1);
  localparam logic [5:0] ROW_LAST = 6'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BYTE0 = 3'd1,
    BYTE1 = 3'd2,
    BYTE2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic [7:0]  byte0_q, byte0_d;   // P0[11:4] held until byte1 arrives
  logic [3:0]  nib_q, nib_d;       // P1[11:8] held until byte2 arrives
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [11:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        in_byte_state;
  logic        accept;
  logic        at_last_pixel;
  logic [5:0]  col_next;
  logic [5:0]  row_next;

  // Ready is combinational so that an abort in the same cycle blocks the
  // byte, and so that ready is low for as long as reset is held.
  always_comb begin
    in_byte_state = (state_q == BYTE0) || (state_q == BYTE1) ||
                    (state_q == BYTE2);
    din_ready     = rst && !abort && in_byte_state;
    accept        = din_valid && din_ready;
  end

  // Row-major pixel cursor: next position after the current pixel.
  always_comb begin
    at_last_pixel = (row_q == ROW_LAST) && (col_q == COL_LAST);
    if (col_q == COL_LAST) begin
      col_next = 6'd0;
      row_next = row_q + 6'd1;
    end else begin
      col_next = col_q + 6'd1;
      row_next = row_q;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    byte0_d = byte0_q;
    nib_d   = nib_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = BYTE0;
          row_d   = 6'd0;
          col_d   = 6'd0;
        end
      end

      BYTE0: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          byte0_d = din;
          state_d = BYTE1;
        end
      end

      BYTE1: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          we_d    = 1'b1;
          waddr_d = {row_q, col_q};
          wdata_d = {byte0_q, din[7:4]};
          nib_d   = din[3:0];
          row_d   = row_next;
          col_d   = col_next;
          state_d = BYTE2;
        end
      end

      BYTE2: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          we_d    = 1'b1;
          waddr_d = {row_q, col_q};
          wdata_d = {nib_q, din};
          // With an even pixel count the final pixel is always a P1.
          if (at_last_pixel) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            row_d   = row_next;
            col_d   = col_next;
            state_d = BYTE0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= 6'd0;
      col_q   <= 6'd0;
      we_q    <= 1'b0;
      waddr_q <= 12'd0;
      wdata_q <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Partial-pixel holding registers need no reset: they are always
  // rewritten before use within a load.
  always_ff @(posedge pclk) begin
    byte0_q <= byte0_d;
    nib_q   <= nib_d;
  end

  always_comb begin
    we    = we_q;
    waddr = waddr_q;
    wdata = wdata_q;
    busy  = busy_q;
    done  = done_q;
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Testbench for sprite_loader (default 48x64 image).
module tb_sprite_loader;

  localparam int W  = 48;
  localparam int H  = 64;
  localparam int N  = W * H;
  localparam int NB = (N * 3) / 2;

  logic        pclk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  din = 8'd0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        we;
  logic [11:0] waddr;
  logic [11:0] wdata;
  logic        busy;
  logic        done;

  sprite_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 pclk = ~pclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input int p);
    return {6'(p / W), 6'(p % W)};
  endfunction

  // Behavioural model: tracks the load as a count of accepted bytes and
  // derives each pixel's address from its linear index.
  int          m_phase = 0;   // 0 idle, 1 loading, 2 final-write cycle
  int          m_bidx = 0;
  logic [7:0]  m_b0 = 8'd0;
  logic [7:0]  m_b1 = 8'd0;
  logic        e_we = 1'b0;
  logic [11:0] e_waddr = 12'd0;
  logic [11:0] e_wdata = 12'd0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;

  always @(posedge pclk) begin
    int k;
    int p;
    e_we   = 1'b0;
    e_done = 1'b0;
    if (!rst) begin
      m_phase = 0;
      e_waddr = 12'd0;
      e_wdata = 12'd0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             m_phase = 1;
             m_bidx  = 0;
           end
        1: if (abort) begin
             m_phase = 0;
           end else if (din_valid) begin
             k = m_bidx % 3;
             p = 2 * (m_bidx / 3) + ((k == 2) ? 1 : 0);
             if (k == 0) begin
               m_b0 = din;
             end else if (k == 1) begin
               e_we    = 1'b1;
               e_waddr = addr_of(p);
               e_wdata = {m_b0, din[7:4]};
               m_b1    = din;
             end else begin
               e_we    = 1'b1;
               e_waddr = addr_of(p);
               e_wdata = {m_b1[3:0], din};
             end
             m_bidx++;
             if (m_bidx == NB) begin
               m_phase = 2;
               e_done  = 1'b1;
             end
           end
        default: m_phase = 0;
      endcase
    end
    e_busy = (m_phase != 0);
  end

  // Per-cycle comparison and write log, sampled mid-cycle.
  logic        chk_en = 1'b0;
  logic [11:0] wlog_addr [4096];
  logic [11:0] wlog_data [4096];
  int          nw = 0;
  int          ndone = 0;
  logic        done_last = 1'b0;
  logic        busy_after = 1'b1;
  logic        prev_done = 1'b0;

  always @(negedge pclk) begin
    if (chk_en) begin
      check("din_ready", 32'(din_ready), 32'(rst && (m_phase == 1) && !abort));
      check("we", 32'(we), 32'(e_we));
      check("waddr", 32'(waddr), 32'(e_waddr));
      check("wdata", 32'(wdata), 32'(e_wdata));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      if (we) begin
        if (nw < 4096) begin
          wlog_addr[nw] = waddr;
          wlog_data[nw] = wdata;
        end
        nw++;
      end
      if (prev_done) busy_after = busy;
      if (done) begin
        ndone++;
        if (we && waddr == 12'hFEF) done_last = 1'b1;
      end
      prev_done = done;
    end
  end

  logic [7:0] lit [3] = '{8'hAB, 8'hCD, 8'hEF};

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic clear_log();
    nw         = 0;
    ndone      = 0;
    done_last  = 1'b0;
    busy_after = 1'b1;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int nbytes, input int gap_max, input int start_at);
    for (int i = 0; i < nbytes; i++) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        int g;
        g = $urandom_range(1, gap_max);
        din_valid = 1'b0;
        for (int j = 0; j < g; j++) begin
          din = 8'($urandom);
          tick();
        end
      end
      din_valid = 1'b1;
      din       = (i < 3) ? lit[i] : 8'($urandom);
      start     = (i == start_at);
      tick();
      start = 1'b0;
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int bad;
    // Reset
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd0);
    rst = 1'b1;
    tick();

    // Full load, din_valid held high
    clear_log();
    start_load();
    feed(NB, 0, -1);
    wait_idle("a_idle");
    tick();
    check("a_writes", nw, 32'd3072);
    check("a_first_addr", 32'(wlog_addr[0]), 32'h000);
    check("a_row0_end", 32'(wlog_addr[47]), 32'h02F);
    check("a_row1_begin", 32'(wlog_addr[48]), 32'h040);
    check("a_last_addr", 32'(wlog_addr[3071]), 32'hFEF);
    check("a_pack0", 32'(wlog_data[0]), 32'hABC);
    check("a_pack1", 32'(wlog_data[1]), 32'hDEF);
    check("a_done_count", ndone, 32'd1);
    check("a_done_with_last", 32'(done_last), 32'd1);
    check("a_busy_after_done", 32'(busy_after), 32'd0);

    // Full load with random gaps and a start pulse mid-load
    clear_log();
    start_load();
    feed(NB, 5, 1000);
    wait_idle("b_idle");
    tick();
    check("b_writes", nw, 32'd3072);
    check("b_done_count", ndone, 32'd1);
    bad = -1;
    for (int p = 0; p < N; p++) begin
      if (bad < 0 && wlog_addr[p] !== addr_of(p)) bad = p;
    end
    check("b_seq_first_bad", bad, -1);

    // Abort after 100 bytes
    clear_log();
    start_load();
    feed(100, 0, -1);
    abort     = 1'b1;
    din_valid = 1'b1;
    din       = 8'($urandom);
    tick();
    abort     = 1'b0;
    din_valid = 1'b0;
    check("c_busy_after_abort", 32'(busy), 32'd0);
    repeat (3) tick();
    check("c_writes_le_67", 32'(nw <= 67), 32'd1);
    check("c_no_done", ndone, 32'd0);

    // Restart after abort begins at address 0
    clear_log();
    start_load();
    feed(6, 0, -1);
    tick();
    tick();
    check("c_restart_writes", nw, 32'd4);
    check("c_restart_addr0", 32'(wlog_addr[0]), 32'h000);
    check("c_restart_addr3", 32'(wlog_addr[3]), 32'h003);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Reset during BYTE1
    clear_log();
    start_load();
    feed(4, 0, -1);
    rst       = 1'b0;
    din_valid = 1'b1;
    din       = 8'($urandom);
    tick();
    check("d_we", 32'(we), 32'd0);
    check("d_waddr", 32'(waddr), 32'd0);
    check("d_wdata", 32'(wdata), 32'd0);
    check("d_busy", 32'(busy), 32'd0);
    check("d_done", 32'(done), 32'd0);
    check("d_din_ready", 32'(din_ready), 32'd0);
    rst = 1'b1;
    nw  = 0;
    for (int i = 0; i < 10; i++) begin
      din = 8'($urandom);
      tick();
    end
    din_valid = 1'b0;
    check("d_no_writes", nw, 32'd0);
    check("d_no_done", ndone, 32'd0);
    check("d_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
SPRITE_LOADER -- requirements
Module: sprite_loader

Interface
REQ-001 Parameter IMG_WIDTH, default 48, sets the image width in pixels; legal range 1..64.
REQ-002 Parameter IMG_HEIGHT, default 64, sets the image height in pixels; legal range 1..64; IMG_WIDTH*IMG_HEIGHT SHALL be even.
REQ-003 Port pclk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-low; it is sampled only on the pclk rising edge.
REQ-005 Port start  input  1  one-cycle request to begin loading one image.
REQ-006 Port abort  input  1  terminates a load in progress.
REQ-007 Port din  input  8  packed pixel byte stream.
REQ-008 Port din_valid  input  1  din holds a valid byte.
REQ-009 Port din_ready  output  1  the loader accepts din in this cycle.
REQ-010 Port we  output  1  write strobe to the 4096x12 sprite RAM.
REQ-011 Port waddr  output  12  RAM address {row[5:0], col[5:0]}.
REQ-012 Port wdata  output  12  RGB 4:4:4 pixel.
REQ-013 Port busy  output  1  a load is in progress.
REQ-014 Port done  output  1  one-cycle pulse when the final pixel has been written.

Function
REQ-015 FSM states SHALL be IDLE, BYTE0, BYTE1, BYTE2 and DONE.
REQ-016 A byte SHALL be accepted only in a cycle where din_valid=1 and din_ready=1.
REQ-017 din_ready SHALL be 1 in BYTE0, BYTE1 and BYTE2, and 0 in IDLE and DONE.
REQ-018 Packing, 3 bytes to 2 pixels: byte0 = P0[11:4]; byte1 = {P0[3:0], P1[11:8]}; byte2 = P1[7:0].
REQ-019 IDLE: if start=1, go to BYTE0 and clear row and col to 0; otherwise remain in IDLE.
REQ-020 BYTE0: on acceptance, latch the byte and go to BYTE1.
REQ-021 BYTE1: on acceptance, issue the P0 write and go to BYTE2.
REQ-022 BYTE2: on acceptance, issue the P1 write and go to BYTE0, or to DONE if P1 is the final pixel.
REQ-023 we, waddr and wdata SHALL be registered; the write appears exactly 1 cycle after the completing byte is accepted, with we high for exactly that 1 cycle.
REQ-024 Pixel order is row-major; col SHALL increment after each write.
REQ-025 When col=IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-026 Addresses with col >= IMG_WIDTH SHALL never be written.
REQ-027 The final pixel is row=IMG_HEIGHT-1, col=IMG_WIDTH-1.
REQ-028 DONE SHALL last 1 cycle with done=1, coinciding with the cycle in which the final we is high, then return to IDLE.
REQ-029 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive, and 0 otherwise.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 No backpressure buffering: when din_valid=0 the FSM SHALL hold its state and counters, with no write issued.
REQ-032 abort=1 in any state other than IDLE SHALL go to IDLE on the next edge, with no done pulse.
REQ-033 On abort, a write already registered from the previous cycle SHALL still complete.
REQ-034 On abort, a byte presented in the abort cycle SHALL NOT be accepted (din_ready=0 that cycle).
REQ-035 abort and start asserted in the same cycle in IDLE: abort SHALL win and the FSM stays in IDLE.
REQ-036 wdata and waddr are don't-care when we=0 but SHALL hold their last values, so they do not toggle.

Reset
REQ-037 When rst=0 at a rising edge: state=IDLE, and row, col, we, waddr, wdata, busy and done all SHALL be 0.
REQ-038 With rst=0, din_ready SHALL be 0.
REQ-039 Reset asserted mid-load SHALL discard partial bytes, with no further writes and no done pulse.

Verification
REQ-040 Full load, default parameters, start then 4608 bytes with din_valid held high -> 3072 writes, one per in-range address, in row-major order:
- first write at waddr=12'h000;
- row 0 ends at 12'h02F;
- row 1 begins at 12'h040;
- last write at 12'hFEF, with done high in that same cycle;
- busy falls 1 cycle later.
REQ-041 Packing, bytes 8'hAB, 8'hCD, 8'hEF -> first write wdata=12'hABC, second write wdata=12'hDEF, each we 1 cycle after its completing byte.
REQ-042 Backpressure: random din_valid gaps, up to 5 cycles -> identical write sequence to REQ-040, with no write during gaps.
REQ-043 Abort after 100 bytes -> at most 67 writes, no done pulse, busy=0 on the cycle following abort, and a new start reloads from 12'h000.
REQ-044 Reset-only: rst=0 during BYTE1 -> the next cycle shows all outputs 0, and after rst=1 no write occurs until start.
REQ-045 Start while busy: start pulsed mid-load -> no restart; addresses continue sequentially.
